// File: rtl/pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipe_cla_addsub
//   Pipelined two's-complement adder/subtractor built from carry-lookahead
//   segments of SEG bits. Each pipeline stage resolves one segment and
//   registers that segment's carry, so the carry chain is broken at every
//   segment boundary. Supports add/sub mode, carry/borrow-in, signed
//   overflow detection, optional saturation and valid/ready flow control.
//   Latency is WIDTH/SEG cycles; throughput is one operation per cycle
//   when the output is not stalled.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operation offered this cycle
//   o_in_ready   operation accepted this cycle (same as pipeline advance)
//   i_a, i_b     operands (two's complement, WIDTH bits)
//   i_sub        0: a+b+cin, 1: a-b-cin
//   i_cin        carry-in (add) / borrow-in (sub)
//   o_out_valid  result valid
//   i_out_ready  downstream accepts the result
//   o_sum        result (clamped on overflow when SAT=1)
//   o_cout       raw carry out of the MSB (sub: 1 = no borrow)
//   o_ovf        signed overflow of the unsaturated result
// ---------------------------------------------------------------------------
module pipe_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int SAT   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int L = WIDTH / SEG;

  // Per-stage registers. r_a/r_b carry the still-unresolved upper operand
  // bits forward; r_sum carries the already-resolved lower result bits.
  logic [WIDTH-1:0] r_a   [L];
  logic [WIDTH-1:0] r_b   [L];
  logic [WIDTH-1:0] r_sum [L];
  logic             r_c   [L];
  logic             r_v   [L];
  logic             r_ovf;

  logic [WIDTH-1:0] w_opA     [L];
  logic [WIDTH-1:0] w_opB     [L];
  logic [WIDTH-1:0] w_sumIn   [L];
  logic [WIDTH-1:0] w_nSum    [L];
  logic             w_cIn     [L];
  logic             w_vIn     [L];
  logic             w_segCout [L];
  logic             w_segCmsb [L];
  logic             w_carry;
  logic             w_g;
  logic             w_p;
  logic             w_advance;
  logic             w_ovf;
  logic [WIDTH-1:0] w_lastSum;

  // No bubble collapsing: the whole pipe either shifts or holds.
  assign w_advance   = !r_v[L-1] | i_out_ready;
  assign o_in_ready  = w_advance;
  assign o_out_valid = r_v[L-1];
  assign o_sum       = r_sum[L-1];
  assign o_cout      = r_c[L-1];
  assign o_ovf       = r_ovf;

  // Stage inputs and segment evaluation. Subtraction is folded in at the
  // entry: a - b - cin == a + ~b + ~cin.
  always_comb begin
    w_carry = 1'b0;
    w_g     = 1'b0;
    w_p     = 1'b0;

    w_opA[0]   = i_a;
    w_opB[0]   = i_sub ? ~i_b : i_b;
    w_cIn[0]   = i_cin ^ i_sub;
    w_sumIn[0] = '0;
    w_vIn[0]   = i_in_valid;
    for (int k = 1; k < L; k++) begin
      w_opA[k]   = r_a[k-1];
      w_opB[k]   = r_b[k-1];
      w_cIn[k]   = r_c[k-1];
      w_sumIn[k] = r_sum[k-1];
      w_vIn[k]   = r_v[k-1];
    end

    for (int k = 0; k < L; k++) begin
      w_nSum[k]    = w_sumIn[k];
      w_segCmsb[k] = 1'b0;
      w_carry      = w_cIn[k];
      for (int i = 0; i < SEG; i++) begin
        w_g = w_opA[k][k*SEG+i] & w_opB[k][k*SEG+i];
        w_p = w_opA[k][k*SEG+i] | w_opB[k][k*SEG+i];
        w_nSum[k][k*SEG+i] = w_opA[k][k*SEG+i] ^ w_opB[k][k*SEG+i] ^ w_carry;
        // Ends holding the carry into the segment's top bit, which for the
        // last segment is the carry into the MSB.
        w_segCmsb[k] = w_carry;
        w_carry = w_g | (w_p & w_carry);
      end
      w_segCout[k] = w_carry;
    end
  end

  // Overflow and optional clamp. On overflow both effective operands share
  // the sign of a, so a's MSB picks the direction of the clamp.
  always_comb begin
    w_ovf     = w_segCmsb[L-1] ^ w_segCout[L-1];
    w_lastSum = w_nSum[L-1];
    if ((SAT != 0) && w_ovf) begin
      w_lastSum = w_opA[L-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < L; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_v[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < L; k++) begin
        r_a[k]   <= w_opA[k];
        r_b[k]   <= w_opB[k];
        r_sum[k] <= (k == L-1) ? w_lastSum : w_nSum[k];
        r_c[k]   <= w_segCout[k];
        r_v[k]   <= w_vIn[k];
      end
      r_ovf <= w_ovf;
    end
  end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_addsub
//   Bench for pipe_cla_addsub (WIDTH=16, SEG=4). Two instances share the
//   same stimulus: one wrapping (SAT=0) and one saturating (SAT=1).
//   Expected results come from a signed/unsigned integer model and a
//   scoreboard queue filled on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_pipe_cla_addsub;

  localparam int LAT = 3;  // edges from the accepting edge until out_valid

  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] satSum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOvf;
    logic [15:0] expSat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        inValid = 1'b0;
  logic        outReady = 1'b1;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        inReady, outValid, cout, ovf;
  logic [15:0] sum;
  logic        inReadyS, outValidS, coutS, ovfS;
  logic [15:0] sumS;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t expQ[$];
  int   retireCycles[$];
  logic        holdActive = 1'b0;
  logic [15:0] holdSum;
  logic        holdCout, holdOvf;

  pipe_cla_addsub #(.WIDTH(16), .SEG(4), .SAT(0)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_a(opA), .i_b(opB), .i_sub(sub), .i_cin(cin),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
  );

  pipe_cla_addsub #(.WIDTH(16), .SEG(4), .SAT(1)) dutSat (
    .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid), .o_in_ready(inReadyS),
    .i_a(opA), .i_b(opB), .i_sub(sub), .i_cin(cin),
    .o_out_valid(outValidS), .i_out_ready(outReady),
    .o_sum(sumS), .o_cout(coutS), .o_ovf(ovfS)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the signed and unsigned views.
  function automatic res_t refModel(input logic [15:0] a, input logic [15:0] b,
                                    input logic s, input logic c);
    res_t r;
    int sa, sb, ua, ub, sres, ures;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    if (s) begin
      sres = sa - sb - int'(c);
      ures = ua - ub - int'(c);
      r.cout = (ures >= 0);
    end else begin
      sres = sa + sb + int'(c);
      ures = ua + ub + int'(c);
      r.cout = (ures > 65535);
    end
    r.sum = sres[15:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    if (sres > 32767)       r.satSum = 16'h7FFF;
    else if (sres < -32768) r.satSum = 16'h8000;
    else                    r.satSum = sres[15:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one operation starting just after a rising edge; returns just
  // after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic c);
    int n;
    opA = a; opB = b; sub = s; cin = c; inValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL accept timeout: in_ready stayed %0b, expected 1", inReady);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitOutput(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!outValid && cycles < 20);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || outValid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain scoreboard", expQ.size(), 0);
  endtask

  task automatic checkConsecutive(input int expCount);
    checkOutput("retire count", retireCycles.size(), expCount);
    for (int i = 1; i < retireCycles.size(); i++)
      checkOutput("retire gap", retireCycles[i] - retireCycles[i-1], 1);
  endtask

  // Scoreboard and output-hold monitor, sampled on the falling edge.
  always @(negedge clk) begin
    res_t e;
    if (!rstN) begin
      expQ.delete();
      holdActive = 1'b0;
    end else begin
      if (holdActive && outValid && !outReady) begin
        checkOutput("hold sum", sum, holdSum);
        checkOutput("hold cout", cout, holdCout);
        checkOutput("hold ovf", ovf, holdOvf);
      end
      holdActive = outValid && !outReady;
      holdSum = sum;
      holdCout = cout;
      holdOvf = ovf;
      if (outValid && outReady) begin
        retireCycles.push_back(cyc);
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected output: sum %h arrived, expected none", sum);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb sum", sum, e.sum);
          checkOutput("sb cout", cout, e.cout);
          checkOutput("sb ovf", ovf, e.ovf);
          checkOutput("sb sat sum", sumS, e.satSum);
          checkOutput("sb sat ovf", ovfS, e.ovf);
          checkOutput("sb sat valid", outValidS, 1);
        end
      end
      if (inValid && inReady) expQ.push_back(refModel(opA, opB, sub, cin));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   cycles;
    logic [15:0] stallSum;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE};
    vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h8000};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[7] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000};

    // Reset state
    #1 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset sat out_valid", outValidS, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", inReady, 1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency measurement
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      waitOutput(cycles);
      checkOutput("vec latency", cycles, LAT);
      checkOutput("vec sum", sum, vecs[i].expSum);
      checkOutput("vec cout", cout, vecs[i].expCout);
      checkOutput("vec ovf", ovf, vecs[i].expOvf);
      checkOutput("vec sat sum", sumS, vecs[i].expSat);
      checkOutput("vec sat ovf", ovfS, vecs[i].expOvf);
    end
    waitDrain();

    // Back-to-back random burst
    retireCycles.delete();
    for (int i = 0; i < 8; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    waitDrain();
    checkConsecutive(8);

    // Fill the pipe with the output stalled, hold, then stream through
    outReady = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    checkOutput("full out_valid", outValid, 1);
    stallSum = sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", inReady, 0);
      checkOutput("stall sum", sum, stallSum);
      checkOutput("stall out_valid", outValid, 1);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    retireCycles.delete();
    for (int i = 0; i < 6; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    waitDrain();
    checkConsecutive(10);

    // Asynchronous reset with operations in flight
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    checkOutput("pre-reset out_valid", outValid, 1);
    checkOutput("pre-reset sum", sum, 16'h2345);
    rstN = 1'b0;
    #1;
    checkOutput("async reset out_valid", outValid, 0);
    checkOutput("async reset sum", sum, 0);
    checkOutput("async reset cout", cout, 0);
    checkOutput("async reset ovf", ovf, 0);
    checkOutput("async reset sat sum", sumS, 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post-reset quiet", outValid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h4000, 16'h0FFF, 1'b1, 1'b1);
    waitOutput(cycles);
    checkOutput("post-reset latency", cycles, LAT);
    checkOutput("post-reset sum", sum, 16'h3000);
    checkOutput("post-reset cout", cout, 1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
